// File: rtl/mac_tx_fifo_arbiter.sv
// mac_tx_fifo_arbiter
//   Shares one MAC TX FIFO write port among N frame writers using the fs/fd
//   handshake. A writer is picked round-robin in IDLE. Its bytes are forwarded
//   to the FIFO with one cycle of latency. When the writer signals fd, the MAC
//   transmitter is started with the byte count of the frame. A per-frame
//   watchdog aborts writers that never finish. Three sticky error flags
//   record timeouts, FIFO overflow and empty frames.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   req[N]     per-writer level request
//   fs[N]      one-hot grant / frame start to the selected writer
//   fd[N]      frame done from each writer
//   din[8N]    writer i byte on bits [8i+7:8i]
//   din_en[N]  writer i byte valid
//   fifo_din   byte to the TX FIFO (registered)
//   fifo_wren  TX FIFO write enable (registered)
//   fifo_full  TX FIFO full
//   mac_fs     MAC frame start, held until mac_fd
//   mac_fd     MAC frame done
//   mac_len    byte count of the frame being sent
//   busy       arbiter is not idle
//   err_clr    one-cycle pulse that clears the sticky errors
//   err        sticky {len_zero, overflow, timeout}
module mac_tx_fifo_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   fs,
  input  logic [N-1:0]   fd,
  input  logic [8*N-1:0] din,
  input  logic [N-1:0]   din_en,
  output logic [7:0]     fifo_din,
  output logic           fifo_wren,
  input  logic           fifo_full,
  output logic           mac_fs,
  input  logic           mac_fd,
  output logic [11:0]    mac_len,
  output logic           busy,
  input  logic           err_clr,
  output logic [2:0]     err
);

  localparam int          PW = (N > 1) ? $clog2(N) : 1;
  localparam int          WW = $clog2(TIMEOUT);
  localparam int unsigned NU = N;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    DRAIN,
    SEND,
    RELEASE,
    ABORT
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, sel, pick;
  logic          pick_valid;
  logic [11:0]   cnt;
  logic [WW-1:0] wdog;
  logic [7:0]    sel_din;
  logic          sel_en, sel_fd;
  logic          set_timeout, set_overflow, set_len_zero;

  // Round-robin search starting just after the last granted writer.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 1; i <= NU; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NU) idx = idx - NU;
      if (!pick_valid && req[idx[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[PW-1:0];
      end
    end
  end

  assign sel_din = din[{sel, 3'b000} +: 8];
  assign sel_en  = din_en[sel];
  assign sel_fd  = fd[sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    set_timeout  = 1'b0;
    set_len_zero = 1'b0;
    set_overflow = (state == GRANT) && sel_en && fifo_full;
    case (state)
      IDLE:    if (pick_valid) state_nxt = GRANT;
      GRANT: begin
        // fd takes priority over a watchdog expiring in the same cycle.
        if (sel_fd) begin
          state_nxt = DRAIN;
        end else if (wdog == WDOG_LAST) begin
          set_timeout = 1'b1;
          state_nxt   = ABORT;
        end
      end
      DRAIN: begin
        if (!sel_fd) begin
          if (cnt == '0) begin
            set_len_zero = 1'b1;
            state_nxt    = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      SEND:    if (mac_fd) state_nxt = RELEASE;
      RELEASE: if (!mac_fd) state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode the state register so reset drops them at once.
  assign fs     = (state == GRANT) ? (N'(1) << sel) : '0;
  assign mac_fs = (state == SEND);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= PW'(N - 1);
      sel       <= '0;
      cnt       <= '0;
      wdog      <= '0;
      mac_len   <= '0;
      err       <= '0;
      fifo_din  <= '0;
      fifo_wren <= 1'b0;
    end else begin
      fifo_wren <= (state == GRANT) && sel_en;
      if ((state == GRANT) && sel_en) fifo_din <= sel_din;
      // A new error event in the clear cycle survives the clear.
      err <= (err_clr ? 3'b000 : err) | {set_len_zero, set_overflow, set_timeout};
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel  <= pick;
            ptr  <= pick;
            cnt  <= '0;
            wdog <= '0;
          end
        end
        GRANT: begin
          if (sel_en && (cnt != '1)) cnt <= cnt + 12'd1;
          wdog <= wdog + WW'(1);
        end
        DRAIN: begin
          if (!sel_fd && (cnt != '0)) mac_len <= cnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_fifo_arbiter.sv
// Testbench for mac_tx_fifo_arbiter. Two instances share the writer-side
// inputs: dut uses the default watchdog, dut_to uses a 16-cycle watchdog for
// the timeout scenarios. Each has its own MAC responder.
module tb_mac_tx_fifo_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, fd, din_en;
  logic [8*N-1:0] din;
  logic           fifo_full, err_clr, mac_fd, mac_fd_to;

  logic [N-1:0] fs, fs_to;
  logic [7:0]   fifo_din, fifo_din_to;
  logic         fifo_wren, fifo_wren_to, mac_fs, mac_fs_to, busy, busy_to;
  logic [11:0]  mac_len, mac_len_to;
  logic [2:0]   err, err_to;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_bytes[$];
  logic [7:0] exp_bytes[$];
  int         got_len[$];
  int         got_grant[$];
  int         onehot_bad;

  always #5 clk = ~clk;

  mac_tx_fifo_arbiter #(.N(N), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .req(req), .fs(fs), .fd(fd), .din(din), .din_en(din_en),
    .fifo_din(fifo_din), .fifo_wren(fifo_wren), .fifo_full(fifo_full),
    .mac_fs(mac_fs), .mac_fd(mac_fd), .mac_len(mac_len), .busy(busy),
    .err_clr(err_clr), .err(err)
  );

  mac_tx_fifo_arbiter #(.N(N), .TIMEOUT(TO)) dut_to (
    .clk(clk), .rst(rst), .req(req), .fs(fs_to), .fd(fd), .din(din), .din_en(din_en),
    .fifo_din(fifo_din_to), .fifo_wren(fifo_wren_to), .fifo_full(fifo_full),
    .mac_fs(mac_fs_to), .mac_fd(mac_fd_to), .mac_len(mac_len_to), .busy(busy_to),
    .err_clr(err_clr), .err(err_to)
  );

  // Monitor on the falling edge: collect FIFO writes, MAC starts, grants.
  initial begin
    logic         mac_fs_q;
    logic [N-1:0] fs_q;
    mac_fs_q   = 1'b0;
    fs_q       = '0;
    onehot_bad = 0;
    forever begin
      @(negedge clk);
      if (fifo_wren === 1'b1) got_bytes.push_back(fifo_din);
      if (mac_fs === 1'b1 && !mac_fs_q) got_len.push_back(int'(mac_len));
      mac_fs_q = (mac_fs === 1'b1);
      if (fs != '0 && fs_q == '0)
        for (int i = 0; i < N; i++) if (fs[i]) got_grant.push_back(i);
      if ((fs & (fs - 1'b1)) != '0) onehot_bad++;
      fs_q = fs;
    end
  end

  // MAC responders: raise mac_fd after a random delay, drop it after mac_fs.
  initial begin
    int d, d2;
    d = 0; d2 = 0; mac_fd = 1'b0; mac_fd_to = 1'b0;
    forever begin
      @(negedge clk);
      if (mac_fs === 1'b1 && !mac_fd) begin
        if (d == 0) begin mac_fd = 1'b1; d = $urandom_range(0, 3); end
        else d--;
      end else if (mac_fs !== 1'b1 && mac_fd) mac_fd = 1'b0;
      if (mac_fs_to === 1'b1 && !mac_fd_to) begin
        if (d2 == 0) begin mac_fd_to = 1'b1; d2 = $urandom_range(0, 3); end
        else d2--;
      end else if (mac_fs_to !== 1'b1 && mac_fd_to) mac_fd_to = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; fd = '0; din_en = '0; din = '0; fifo_full = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic clear_queues();
    got_bytes.delete(); exp_bytes.delete(); got_len.delete(); got_grant.delete();
    onehot_bad = 0;
  endtask

  // Reference arbitration: first requester after p, wrapping around.
  function automatic int model_pick(input int p, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Acts as whichever writer gets granted on dut. drop: 0 keep req,
  // 1 drop own req, 2 drop all reqs. full_mask bit i raises fifo_full with
  // byte i; err_clr is pulsed together with byte clr_at.
  task automatic serve(input int nbytes, input int full_mask, input int clr_at,
                       input int drop, output int w, output bit ok);
    int b;
    logic [7:0] v;
    ok = 1'b1; w = -1; b = 0;
    while (fs == '0 && b < 100) begin tick(); b++; end
    if (fs == '0) begin ok = 1'b0; return; end
    for (int i = 0; i < N; i++) if (fs[i]) w = i;
    if (drop == 1) req[w] = 1'b0;
    else if (drop == 2) req = '0;
    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
      v = 8'($urandom);
      din[w*8 +: 8] = v;
      din_en[w]     = 1'b1;
      fifo_full     = (i < 32) ? full_mask[i] : 1'b0;
      err_clr       = (i == clr_at);
      exp_bytes.push_back(v);
      tick();
      din_en[w] = 1'b0; fifo_full = 1'b0; err_clr = 1'b0;
    end
    fd[w] = 1'b1;
    tick();
    fd[w] = 1'b0;
    b = 0;
    while (busy !== 1'b0 && b < 100) begin tick(); b++; end
    if (busy !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++; if (fs !== 4'b0000) begin errors++; $display("FAIL reset_fs: got %b expected 0000", fs); end
    checks++; if (fifo_wren !== 1'b0) begin errors++; $display("FAIL reset_fifo_wren: got %b expected 0", fifo_wren); end
    checks++; if (fifo_din !== 8'h00) begin errors++; $display("FAIL reset_fifo_din: got %h expected 00", fifo_din); end
    checks++; if (mac_fs !== 1'b0) begin errors++; $display("FAIL reset_mac_fs: got %b expected 0", mac_fs); end
    checks++; if (mac_len !== 12'd0) begin errors++; $display("FAIL reset_mac_len: got %0d expected 0", mac_len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", err); end
    do_reset();
  endtask

  task automatic test_single_writer();
    int b;
    clear_queues();
    req = 4'b0001;
    b = 0;
    while (fs == '0 && b < 20) begin tick(); b++; end
    checks++; if (fs !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", fs); end
    req = '0;
    for (int i = 0; i < 128; i++) begin
      din[7:0] = 8'(i); din_en[0] = 1'b1;
      tick();
      checks++;
      if (fifo_wren !== 1'b1 || fifo_din !== 8'(i)) begin
        errors++; $display("FAIL single_byte%0d: got wren=%b din=%h expected wren=1 din=%h", i, fifo_wren, fifo_din, 8'(i));
      end
    end
    din_en = '0; fd[0] = 1'b1;
    tick();
    fd = '0;
    checks++; if (fifo_wren !== 1'b0) begin errors++; $display("FAIL single_wren_after: got %b expected 0", fifo_wren); end
    b = 0;
    while (mac_fs !== 1'b1 && b < 20) begin tick(); b++; end
    checks++; if (mac_fs !== 1'b1) begin errors++; $display("FAIL single_mac_fs: got %b expected 1", mac_fs); end
    checks++; if (mac_len !== 12'd128) begin errors++; $display("FAIL single_mac_len: got %0d expected 128", mac_len); end
    b = 0;
    while (busy !== 1'b0 && b < 20) begin tick(); b++; end
    checks++; if (busy !== 1'b0 || mac_fs !== 1'b0) begin errors++; $display("FAIL single_release: got busy=%b mac_fs=%b expected 0 0", busy, mac_fs); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL single_err: got %b expected 000", err); end
    checks++; if (got_bytes.size() != 128) begin errors++; $display("FAIL single_nbytes: got %0d expected 128", got_bytes.size()); end
  endtask

  task automatic test_contention();
    int mptr, exp, w, bad;
    bit ok;
    int exp_grant[$];
    do_reset();
    clear_queues();
    mptr = N - 1;
    req  = '1;
    for (int k = 0; k < 5; k++) begin
      exp = model_pick(mptr, req);
      exp_grant.push_back(exp);
      serve(10, 0, -1, (k == 4) ? 2 : 0, w, ok);
      checks++; if (!ok) begin errors++; $display("FAIL contention_frame%0d_done: got ok=0 expected ok=1", k); end
      checks++; if (w != exp) begin errors++; $display("FAIL contention_grant%0d: got %0d expected %0d", k, w, exp); end
      mptr = exp;
    end
    checks++;
    if (got_grant != exp_grant) begin errors++; $display("FAIL contention_order: got %p expected %p", got_grant, exp_grant); end
    checks++; if (got_len.size() != 5) begin errors++; $display("FAIL contention_nframes: got %0d expected 5", got_len.size()); end
    foreach (got_len[i]) begin
      checks++; if (got_len[i] != 10) begin errors++; $display("FAIL contention_len%0d: got %0d expected 10", i, got_len[i]); end
    end
    checks++; if (onehot_bad != 0) begin errors++; $display("FAIL contention_onehot: got %0d violations expected 0", onehot_bad); end
    bad = (got_bytes.size() != exp_bytes.size()) ? 1 : 0;
    foreach (exp_bytes[i]) if (i < got_bytes.size() && got_bytes[i] !== exp_bytes[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL contention_bytes: got %0d bytes, %0d bad, expected %0d bytes", got_bytes.size(), bad, exp_bytes.size()); end
  endtask

  task automatic test_overflow_zero();
    int w;
    bit ok;
    clear_queues();
    req = 4'b0010;
    serve(5, 5'b11111, -1, 1, w, ok);
    checks++; if (!ok || w != 1) begin errors++; $display("FAIL ovf_frame: got ok=%0d w=%0d expected ok=1 w=1", ok, w); end
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL ovf_err: got %b expected 010", err); end
    checks++; if (got_len.size() != 1 || mac_len !== 12'd5) begin errors++; $display("FAIL ovf_len: got n=%0d len=%0d expected n=1 len=5", got_len.size(), mac_len); end
    req = 4'b0100;
    serve(0, 0, -1, 1, w, ok);
    checks++; if (!ok || w != 2) begin errors++; $display("FAIL zero_frame: got ok=%0d w=%0d expected ok=1 w=2", ok, w); end
    checks++; if (err !== 3'b110) begin errors++; $display("FAIL zero_err: got %b expected 110", err); end
    checks++; if (got_len.size() != 1 || mac_len !== 12'd5) begin errors++; $display("FAIL zero_no_mac: got n=%0d len=%0d expected n=1 len=5", got_len.size(), mac_len); end
    req = 4'b1000;
    serve(3, 1, 0, 1, w, ok);
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL set_wins_err: got %b expected 010", err); end
    checks++; if (got_len.size() != 2 || mac_len !== 12'd3) begin errors++; $display("FAIL set_wins_len: got n=%0d len=%0d expected n=2 len=3", got_len.size(), mac_len); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL err_clr: got %b expected 000", err); end
    checks++; if (got_bytes != exp_bytes) begin errors++; $display("FAIL ovf_bytes: got %p expected %p", got_bytes, exp_bytes); end
  endtask

  task automatic test_random();
    int mptr, exp, w, n, fm;
    bit ok;
    logic [N-1:0] mask;
    logic [2:0]   merr;
    int exp_len[$];
    do_reset();
    clear_queues();
    mptr = N - 1;
    merr = '0;
    for (int f = 0; f < 12; f++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      req  = mask;
      exp  = model_pick(mptr, mask);
      n    = $urandom_range(0, 12);
      fm   = ($urandom_range(0, 3) == 0) ? int'($urandom) & ((1 << n) - 1) : 0;
      if (fm != 0) merr[1] = 1'b1;
      if (n == 0) merr[2] = 1'b1;
      else exp_len.push_back(n);
      serve(n, fm, -1, 2, w, ok);
      checks++; if (!ok || w != exp) begin errors++; $display("FAIL rand_grant%0d: got ok=%0d w=%0d expected ok=1 w=%0d", f, ok, w, exp); end
      checks++; if (err !== merr) begin errors++; $display("FAIL rand_err%0d: got %b expected %b", f, err, merr); end
      mptr = exp;
    end
    checks++; if (got_len != exp_len) begin errors++; $display("FAIL rand_lens: got %p expected %p", got_len, exp_len); end
    checks++; if (got_bytes != exp_bytes) begin errors++; $display("FAIL rand_bytes: got %0d bytes expected %0d", got_bytes.size(), exp_bytes.size()); end
  endtask

  task automatic test_timeout();
    int hi, b;
    bit saw_mac;
    do_reset();
    hi = 0; saw_mac = 1'b0;
    req = 4'b0100;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (mac_fs_to === 1'b1) saw_mac = 1'b1;
      if (fs_to[2] === 1'b1) begin hi++; req = 4'b1000; end
      else if (hi > 0) break;
    end
    checks++; if (hi != TO) begin errors++; $display("FAIL timeout_fs_cycles: got %0d expected %0d", hi, TO); end
    checks++; if (err_to !== 3'b001) begin errors++; $display("FAIL timeout_err: got %b expected 001", err_to); end
    b = 0;
    while (fs_to == '0 && b < 10) begin
      tick(); b++;
      if (mac_fs_to === 1'b1) saw_mac = 1'b1;
    end
    checks++; if (fs_to !== 4'b1000) begin errors++; $display("FAIL timeout_next_grant: got %b expected 1000", fs_to); end
    checks++; if (saw_mac) begin errors++; $display("FAIL timeout_mac_fs: got 1 expected 0"); end
  endtask

  task automatic test_fd_vs_timeout();
    int b;
    do_reset();
    req = 4'b0001;
    b = 0;
    while (fs_to == '0 && b < 20) begin tick(); b++; end
    req = '0;
    for (int i = 0; i < TO - 1; i++) begin
      din[7:0] = 8'($urandom); din_en[0] = 1'b1;
      tick();
    end
    din_en = '0; fd[0] = 1'b1;
    tick();
    fd = '0;
    checks++; if (fs_to !== 4'b0000 || err_to !== 3'b000) begin errors++; $display("FAIL fdwins_state: got fs=%b err=%b expected 0000 000", fs_to, err_to); end
    b = 0;
    while (mac_fs_to !== 1'b1 && b < 20) begin tick(); b++; end
    checks++; if (mac_fs_to !== 1'b1 || mac_len_to !== 12'(TO - 1)) begin errors++; $display("FAIL fdwins_mac: got mac_fs=%b len=%0d expected 1 %0d", mac_fs_to, mac_len_to, TO - 1); end
    b = 0;
    while (busy_to !== 1'b0 && b < 20) begin tick(); b++; end
    checks++; if (busy_to !== 1'b0 || err_to !== 3'b000) begin errors++; $display("FAIL fdwins_done: got busy=%b err=%b expected 0 000", busy_to, err_to); end
  endtask

  task automatic test_reset_mid_frame();
    int b, w;
    bit ok;
    do_reset();
    clear_queues();
    req = 4'b0001;
    b = 0;
    while (fs == '0 && b < 20) begin tick(); b++; end
    req = '0;
    for (int i = 0; i < 3; i++) begin
      din[7:0] = 8'(8'hA0 + i); din_en[0] = 1'b1;
      tick();
    end
    checks++; if (fifo_wren !== 1'b1 || fs !== 4'b0001) begin errors++; $display("FAIL midrst_pre: got wren=%b fs=%b expected 1 0001", fifo_wren, fs); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (fs !== 4'b0000 || fifo_wren !== 1'b0 || mac_fs !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got fs=%b wren=%b mac_fs=%b busy=%b expected all 0", fs, fifo_wren, mac_fs, busy);
    end
    din_en = '0;
    tick();
    rst = 1'b1;
    tick();
    clear_queues();
    req = 4'b0010;
    serve(2, 0, -1, 1, w, ok);
    checks++; if (!ok || w != 1) begin errors++; $display("FAIL midrst_regrant: got ok=%0d w=%0d expected ok=1 w=1", ok, w); end
    checks++; if (got_len.size() != 1 || mac_len !== 12'd2) begin errors++; $display("FAIL midrst_len: got n=%0d len=%0d expected n=1 len=2", got_len.size(), mac_len); end
  endtask

  initial begin
    test_reset();
    test_single_writer();
    test_contention();
    test_overflow_zero();
    test_random();
    test_timeout();
    test_fd_vs_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_fifo_arbiter.md
Name: mac_tx_fifo_arbiter

Overview:
- Shares the single MAC TX FIFO write port among N frame writers that use the fs/fd handshake.
- Sequences each frame: grant writer, pass its bytes into the FIFO, then start the MAC transmitter with the written byte count.
- Sits between the payload writers and the TX FIFO/MAC TX engine.
- Round-robin fairness, per-frame watchdog, sticky error flags.

Parameters:
- N, 4, number of writers (2..8).
- TIMEOUT, 4096, max cycles a granted writer may take before fd (>=16).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  N  per-writer level request; a writer holds it until it sees its fs.
- fs  out  N  one-hot grant/frame start to writer i.
- fd  in  N  frame done from writer i.
- din  in  8*N  writer i byte on bits [8i+7:8i].
- din_en  in  N  writer i byte valid.
- fifo_din  out  8  byte to TX FIFO.
- fifo_wren  out  1  TX FIFO write enable.
- fifo_full  in  1  TX FIFO full.
- mac_fs  out  1  MAC frame start.
- mac_fd  in  1  MAC frame done.
- mac_len  out  12  byte count of the frame being sent.
- busy  out  1  state != IDLE.
- err_clr  in  1  one-cycle pulse clears all sticky errors.
- err  out  3  sticky {len_zero, overflow, timeout}.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = N-1, so writer 0 has first priority.
- States and transitions:
  - IDLE: if any req, pick the first set bit searching from ptr+1 with wrap. Register sel, set ptr = sel, clear cnt/wdog, go GRANT. fs[sel] is high from the next cycle.
  - GRANT: fs[sel]=1. Each cycle with din_en[sel], cnt++ (saturate 4095). wdog++.
    - fd[sel]=1 -> DRAIN.
    - wdog == TIMEOUT-1 -> set err[0], ABORT.
  - DRAIN: fs=0. Wait fd[sel]=0.
    - cnt==0: set err[2], go IDLE (no MAC start).
    - Else: mac_len<=cnt, go SEND.
  - SEND: mac_fs=1 until mac_fd=1 -> RELEASE.
  - RELEASE: mac_fs=0. Wait mac_fd=0 -> IDLE.
  - ABORT: fs=0 for one cycle, then IDLE. The MAC is not started. The FIFO is not flushed; the owner of the FIFO handles that via its own reset.
- Datapath: fifo_din/fifo_wren are registered from din[sel]/din_en[sel], 1-cycle latency, only in GRANT. din_en from non-selected writers is ignored.
- fifo_full & din_en[sel] in GRANT: the byte is still presented (writers cannot stall) and err[1] is set.
- fifo_wren may be high in the first DRAIN cycle, carrying the last GRANT byte. It is never high in any other non-GRANT state.
- mac_len holds its value from DRAIN exit until the next DRAIN exit.
- Arbitration is evaluated only in IDLE; req changes in other states are ignored. There is one IDLE cycle minimum between frames.
- Simultaneous req with ptr=k: grant goes to the lowest index > k, with wrap.
- err_clr and a new error event in the same cycle: the error is set (set wins).
- fd[sel] and wdog expiry in the same cycle: fd wins (DRAIN, no timeout).
- A reset mid-frame forces IDLE immediately and drops fs, mac_fs and fifo_wren asynchronously.
- Arithmetic: cnt and wdog are 12-bit (wdog sized clog2(TIMEOUT)), unsigned. mac_len = cnt.

Test Plan:
- Single writer: req[0]=1, then 128 din_en bytes 0x00..0x7F, then fd.
  - fifo_wren is high for 128 cycles with matching bytes, 1-cycle delayed.
  - mac_fs rises with mac_len=128 and drops after mac_fd; busy then returns to 0.
- Contention: req=4'b1111 held, every writer sends 10 bytes.
  - Grant order is 0,1,2,3,0.
  - Each frame has mac_len=10, and fs is never more than one-hot.
- Timeout: TIMEOUT=16, writer 2 is granted but never asserts fd.
  - fs[2] drops after 16 cycles and err=3'b001.
  - mac_fs stays 0, then writer 3 is served next.
- Overflow and zero length:
  - fifo_full=1 during 5 bytes -> err[1]=1, frame still sent with mac_len=5.
  - A frame with fd but no din_en -> err[2]=1 and no mac_fs.
  - err_clr pulse -> err=0.
- Reset mid-frame: rst=0 in GRANT after 3 bytes.
  - Outputs go to 0 at once.
  - After release, req[1] alone is granted first with cnt restarting at 0.
